// File: rtl/b_sram_rd_ctrl.sv
// Read-side controller for the B_SRAM buffer: fetches one word per entry and streams it as LANES lanes.
// Optional macro B_SRAM_RD_MSB_FIRST_EN reverses lane order (most significant lane first).
module b_sram_rd_ctrl #(
    parameter int WIDTH_ADR  = 2,
    parameter int WIDTH_LANE = 72,
    parameter int LANES      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH_ADR:0]            wr_ptr,
    output logic [WIDTH_ADR:0]            rd_ptr,
    output logic [WIDTH_ADR-1:0]          rd_adr,
    input  logic [WIDTH_LANE*LANES-1:0]   rd_dto,
    output logic [WIDTH_LANE-1:0]         out_dt,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic                          empty,
    output logic                          full
);

    localparam int WORD_W = WIDTH_LANE * LANES;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t              state_q;
    logic [WIDTH_ADR:0]  rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0]   word_q;
    logic [LIDX_W-1:0]   lane_q, lane_d;
    logic                out_vld_q;

    function automatic logic [WIDTH_LANE-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                       input logic [LIDX_W-1:0] k);
        int idx;
`ifdef B_SRAM_RD_MSB_FIRST_EN
        idx = LANES - 1 - int'(k);
`else
        idx = int'(k);
`endif
        return w[idx*WIDTH_LANE +: WIDTH_LANE];
    endfunction

    assign rd_ptr_d = rd_ptr_q + {{WIDTH_ADR{1'b0}}, 1'b1};
    assign lane_d   = lane_q + {{(LIDX_W-1){1'b0}}, 1'b1};

    assign empty = (rd_ptr_q == wr_ptr);
    assign full  = (rd_ptr_q[WIDTH_ADR] != wr_ptr[WIDTH_ADR]) &&
                   (rd_ptr_q[WIDTH_ADR-1:0] == wr_ptr[WIDTH_ADR-1:0]);

    assign rd_ptr  = rd_ptr_q;
    assign rd_adr  = rd_ptr_q[WIDTH_ADR-1:0];
    assign out_vld = out_vld_q;
    assign out_dt  = lane_sel(word_q, lane_q);

    // The entry is released at capture; the lanes drain from word_q, so the writer may reuse it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    word_q    <= rd_dto;
                    rd_ptr_q  <= rd_ptr_d;
                    lane_q    <= '0;
                    out_vld_q <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (out_rdy) begin
                        if (lane_q == LAST_LANE) begin
                            out_vld_q <= 1'b0;
                            state_q   <= empty ? IDLE : FETCH;
                        end else begin
                            lane_q <= lane_d;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/b_sram_rd_ctrl.md
# b_sram_rd_ctrl

Read-side controller for the 4-entry, 288-bit B_SRAM buffer in the FIFO datapath. It compares its own read pointer with the write pointer from the write side and fetches each stored word through the B_SRAM read port. Each word is returned as four 72-bit lanes on a valid/ready stream. It is the consumer end of the buffer and exports `full`/`empty` status so the write side can throttle itself.

## Interface
Parameters:
- `WIDTH_ADR`, 2: B_SRAM address width; depth = 2^WIDTH_ADR.
- `WIDTH_LANE`, 72: output lane width.
- `LANES`, 4: lanes per B_SRAM word; word width = WIDTH_LANE*LANES = 288.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `wr_ptr`  in  WIDTH_ADR+1  write-side pointer; MSB is the wrap bit.
- `rd_ptr`  out  WIDTH_ADR+1  read pointer returned to the write side.
- `rd_adr`  out  WIDTH_ADR  B_SRAM read address, equal to `rd_ptr[WIDTH_ADR-1:0]`.
- `rd_dto`  in  WIDTH_LANE*LANES  B_SRAM read data.
- `out_dt`  out  WIDTH_LANE  current lane.
- `out_vld`  out  1  `out_dt` is valid.
- `out_rdy`  in  1  sink accepts the lane.
- `empty`  out  1  `rd_ptr == wr_ptr`.
- `full`  out  1  MSBs differ and the low WIDTH_ADR bits are equal.

## Operation
- State machine:
  - IDLE: leave to FETCH when `!empty`.
  - FETCH: one cycle; `rd_adr` has been stable for at least one full cycle. At the closing edge, capture `rd_dto` into the word register, set `rd_ptr <= rd_ptr+1` (modulo 2^(WIDTH_ADR+1)), set lane index to 0, go to SEND.
  - SEND: `out_vld=1` and `out_dt` = the selected lane. On `out_vld && out_rdy`, increment the lane index. When lane LANES-1 is accepted, go to FETCH if `!empty` (evaluated with the already-incremented `rd_ptr`), otherwise go to IDLE.
- The B_SRAM entry is released at capture, not at the last lane. The write side may overwrite it while its lanes are still draining.
- Lane selection without the macro: lane k = `word[k*WIDTH_LANE +: WIDTH_LANE]`, so lane 0 (bits 71:0) goes out first.
- `out_dt` holds its value while `out_vld && !out_rdy` (stall). Lane index and state do not advance.
- `empty`/`full` are combinational from the two pointers. Overflow prevention is the write side's duty using `full`.
- A change to `wr_ptr` during SEND has no effect until the last lane is accepted.
- Wrap-around: `rd_ptr` runs 7→0 with the MSB toggling; `rd_adr` runs 3→0.

## Timing
- Reset values: `rd_ptr=0`, `rd_adr=0`, `out_vld=0`, `out_dt=0`, word register 0, lane index 0, state IDLE. `empty=1` when `wr_ptr=0`.
- Reset mid-operation returns to IDLE immediately and drops the in-flight word. Both sides must be reset together.
- Latency:
  - Write at edge N (`wr_ptr` updated at N).
  - IDLE→FETCH at edge N+1.
  - Capture at edge N+2.
  - First `out_vld` in the cycle after N+2.
- B_SRAM read latency budget: at most one cycle. Both combinational and registered read ports are valid.
- Throughput with `out_rdy` held high: 4 lane cycles plus 1 FETCH bubble per word, i.e. 5 cycles per word.
- `out_vld` never drops while a word has lanes remaining.

## Configuration
- `B_SRAM_RD_MSB_FIRST_EN`:
  - Defined: lane k = `word[(LANES-1-k)*WIDTH_LANE +: WIDTH_LANE]`; bits 287:216 are emitted first.
  - Undefined: LSB-first order as in Operation.
  - Pointer, handshake and timing are unchanged either way.

## Test plan
- Reset, `wr_ptr=0`: `empty=1`, `full=0`, `out_vld=0`, `rd_adr=0`, with no state change over 10 cycles.
- Preload entry 1 = 'ha and set `rd_ptr` to 1 via one dummy word; raise `wr_ptr` to 2 with `out_rdy=1`.
  - Required: lanes 'ha, 0, 0, 0 on consecutive cycles, `out_vld` high 2 cycles after the `wr_ptr` edge, then `empty=1`.
- Entries 1–3 = 'ha, 'hb, 'hc, `wr_ptr` advanced to 4: 12 lanes in order with one-cycle bubbles between words; `rd_ptr` ends at 4.
- Stall: drop `out_rdy` for 3 cycles on lane 2. Required: `out_dt` and `out_vld` hold, and exactly 4 lanes are delivered.
- Wrap/full: write-side `wr_ptr` = `rd_ptr`+4. Required: `full=1`; after one capture `full=0`; then drain past 7→0 with correct data from `rd_adr` 3 then 0.
- Assert `rst_n` low during lane 1 of a word: outputs drop to reset values asynchronously. After release the controller is IDLE with `rd_ptr=0`; with `B_SRAM_RD_MSB_FIRST_EN` defined, rerun scenario 2 and require lanes 0, 0, 0, 'ha.
